// File: rtl/pwm_out_pkg.sv
// pwm_out_pkg
// Shared definitions for the PWM output generator: FSM state encoding,
// bit positions inside the stop control word and the default datapath width.
// No ports (package).

package pwm_out_pkg;

  // Datapath width used when the instantiating design does not override it.
  localparam int DEFAULT_W = 32;

  // Bit positions in the stop control word.
  localparam int STOP_GRACEFUL  = 0;
  localparam int STOP_IMMEDIATE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_ramp.sv
// pwm_ramp
// Combinational duty slew limiter. Moves the current duty toward the target
// by at most 'step', clamped so the result never overshoots the target.
// Ports:
//   cur_duty    - duty currently in effect
//   target_duty - duty requested by software
//   step        - largest change allowed in one update
//   next_duty   - duty to load at the next shadow update

module pwm_ramp #(
  parameter int W = 32
) (
  input  logic [W-1:0] cur_duty,
  input  logic [W-1:0] target_duty,
  input  logic [W-1:0] step,
  output logic [W-1:0] next_duty
);

  // The differences are only formed in the direction that cannot underflow,
  // and cur +/- step is only used when the gap exceeds step, so nothing wraps.
  always_comb begin
    next_duty = target_duty;
    if (target_duty > cur_duty) begin
      if ((target_duty - cur_duty) > step) next_duty = cur_duty + step;
    end else begin
      if ((cur_duty - target_duty) > step) next_duty = cur_duty - step;
    end
  end

endmodule

// File: rtl/pwm_out_gen.sv
// pwm_out_gen
// PWM generator fed by the Nios period/duty/stop PIO words. Period and duty
// are double-buffered into shadow registers that only update at period
// boundaries, so software writes never cause runt or glitched pulses.
// Stop is graceful (finish the current period) or immediate.
// Optional build macro: PWM_RAMP_EN - slew-limit duty changes by RAMP_STEP
// per period, starting every run from zero duty (soft start).
// Ports:
//   clk_clk       - system clock (same domain as the PIOs)
//   reset_reset_n - asynchronous active-low reset
//   period_in     - requested period in clocks
//   duty_in       - requested high time in clocks
//   stop_in       - bit 0 graceful stop, bit 1 immediate stop, rest ignored
//   pwm_out       - registered PWM waveform
//   period_tick   - one-cycle pulse on the last clock of each running period
//   active        - high while the generator is running or draining

module pwm_out_gen
  import pwm_out_pkg::*;
#(
  parameter int W          = DEFAULT_W,
  parameter int MIN_PERIOD = 2,
  parameter int RAMP_STEP  = 1000
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] duty_in,
  input  logic [31:0]  stop_in,
  output logic         pwm_out,
  output logic         period_tick,
  output logic         active
);

  localparam logic [W-1:0] MIN_P = W'(MIN_PERIOD);

  logic [W-1:0] r_period, r_duty;
  logic [1:0]   r_stop;

  pwm_state_e   state, state_next;
  logic [W-1:0] cnt, cnt_next;
  logic [W-1:0] period_sh, period_next;
  logic [W-1:0] duty_sh, duty_next;
  logic [W-1:0] duty_load;
  logic         end_of_period;
  logic         period_ok;

  assign end_of_period = (cnt == (period_sh - W'(1)));
  assign period_ok     = (r_period >= MIN_P);

`ifdef PWM_RAMP_EN
  // A run always starts ramping from zero; later loads ramp from the
  // duty currently in effect.
  logic [W-1:0] ramp_cur;
  logic         unused_stop;

  assign ramp_cur    = (state == IDLE) ? '0 : duty_sh;
  assign unused_stop = ^stop_in[31:2];

  pwm_ramp #(.W(W)) u_ramp (
    .cur_duty    (ramp_cur),
    .target_duty (r_duty),
    .step        (W'(RAMP_STEP)),
    .next_duty   (duty_load)
  );
`else
  logic unused_cfg;

  assign duty_load  = r_duty;
  assign unused_cfg = ^{stop_in[31:2], 32'(RAMP_STEP)};
`endif

  // Input stage; the PIOs share this clock so no synchronizer is needed.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_period <= '0;
      r_duty   <= '0;
      r_stop   <= '0;
    end else begin
      r_period <= period_in;
      r_duty   <= duty_in;
      r_stop   <= stop_in[1:0];
    end
  end

  // State, counter and shadow registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      period_sh <= period_next;
      duty_sh   <= duty_next;
    end
  end

  // Next-state logic. Immediate stop is checked before graceful stop so it
  // wins when both bits are set. A graceful stop arriving exactly on a
  // boundary still lets that boundary reload, then drains the new period.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    period_next = period_sh;
    duty_next   = duty_sh;
    case (state)
      IDLE: begin
        if ((r_stop == 2'b00) && period_ok) begin
          state_next  = RUN;
          cnt_next    = '0;
          period_next = r_period;
          duty_next   = duty_load;
        end
      end
      RUN: begin
        if (r_stop[STOP_IMMEDIATE]) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          if (r_stop[STOP_GRACEFUL]) state_next = DRAIN;
          if (end_of_period) begin
            cnt_next  = '0;
            duty_next = duty_load;
            if (period_ok) period_next = r_period;
          end else begin
            cnt_next = cnt + W'(1);
          end
        end
      end
      DRAIN: begin
        if (r_stop[STOP_IMMEDIATE] || end_of_period) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the same state/cnt so pwm_out, period_tick
  // and active stay cycle-aligned; duty_sh >= period_sh naturally yields a
  // constant high because cnt never reaches period_sh.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      active      <= 1'b0;
    end else begin
      pwm_out     <= (state != IDLE) && (cnt < duty_sh);
      period_tick <= (state != IDLE) && end_of_period;
      active      <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_out_gen.sv
// tb_pwm_out_gen
// Directed testbench for pwm_out_gen. Each scenario restarts the DUT from
// reset, releases the stop word and then walks edge by edge (edge 1 is the
// first clock after stop_in clears), comparing pwm_out, period_tick and
// active against hand-derived waveforms.

module tb_pwm_out_gen;

  localparam int W = 32;

  logic         clk_clk;
  logic         reset_reset_n;
  logic [W-1:0] period_in;
  logic [W-1:0] duty_in;
  logic [31:0]  stop_in;
  logic         pwm_out;
  logic         period_tick;
  logic         active;

  int tests_run;
  int tests_failed;

  pwm_out_gen #(
    .W          (W),
    .MIN_PERIOD (2),
    .RAMP_STEP  (2)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .period_in     (period_in),
    .duty_in       (duty_in),
    .stop_in       (stop_in),
    .pwm_out       (pwm_out),
    .period_tick   (period_tick),
    .active        (active)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Reset, load period/duty while held stopped, then clear stop so the
  // following tick() is edge 1.
  task automatic start_run(input logic [W-1:0] p, input logic [W-1:0] d);
    reset_reset_n = 1'b0;
    period_in     = p;
    duty_in       = d;
    stop_in       = 32'h2;
    #3;
    reset_reset_n = 1'b1;
    tick();
    tick();
    stop_in = 32'h0;
  endtask

  task automatic test_reset();
    logic exp_pwm;
    reset_reset_n = 1'b0;
    period_in     = 10;
    duty_in       = 3;
    stop_in       = 0;
    #3;
    tests_run++;
    if ({pwm_out, period_tick, active} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b want 000", {pwm_out, period_tick, active});
    end
    start_run(10, 3);
    for (int k = 1; k <= 3; k++) tick();
    exp_pwm = 1'b1;
    tests_run++;
    if (pwm_out !== exp_pwm) begin
      tests_failed++;
      $display("[TB] FAIL pre_async_reset_pwm: got %b want %b", pwm_out, exp_pwm);
    end
    #2;
    reset_reset_n = 1'b0;
    #1;
    tests_run++;
    if ({pwm_out, active} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_mid_high: got %b want 00", {pwm_out, active});
    end
    reset_reset_n = 1'b1;
  endtask

  task automatic test_basic_run();
    logic exp_pwm, exp_tick, exp_act;
    int ph;
    start_run(10, 3);
    for (int k = 1; k <= 32; k++) begin
      tick();
      ph       = (k - 3) % 10;
      exp_act  = (k >= 3);
      exp_pwm  = (k >= 3) && (ph < 3);
      exp_tick = (k >= 3) && (ph == 9);
      tests_run++;
      if ({pwm_out, period_tick, active} !== {exp_pwm, exp_tick, exp_act}) begin
        tests_failed++;
        $display("[TB] FAIL basic_run edge %0d: got pwm/tick/act %b want %b",
                 k, {pwm_out, period_tick, active}, {exp_pwm, exp_tick, exp_act});
      end
    end
  endtask

  task automatic test_mid_update();
    logic exp_pwm;
    int ph, hi;
    start_run(10, 3);
    for (int k = 1; k <= 22; k++) begin
      tick();
      ph      = (k - 3) % 10;
      hi      = (k >= 13) ? 7 : 3;
      exp_pwm = (k >= 3) && (ph < hi);
      tests_run++;
      if (pwm_out !== exp_pwm) begin
        tests_failed++;
        $display("[TB] FAIL mid_update edge %0d: got %b want %b", k, pwm_out, exp_pwm);
      end
      if (k == 6) duty_in = 7;
    end
  endtask

  task automatic test_edge_duties();
    logic [W-1:0] duties [3];
    logic exp_pwm, exp_tick;
    int ph;
    duties[0] = 0;
    duties[1] = 8;
    duties[2] = 50;
    for (int i = 0; i < 3; i++) begin
      start_run(8, duties[i]);
      for (int k = 1; k <= 22; k++) begin
        tick();
        ph       = (k - 3) % 8;
        exp_pwm  = (k >= 3) && (duties[i] != 0);
        exp_tick = (k >= 3) && (ph == 7);
        tests_run++;
        if ({pwm_out, period_tick} !== {exp_pwm, exp_tick}) begin
          tests_failed++;
          $display("[TB] FAIL edge_duty %0d edge %0d: got pwm/tick %b want %b",
                   duties[i], k, {pwm_out, period_tick}, {exp_pwm, exp_tick});
        end
      end
    end
  endtask

  task automatic test_graceful_stop();
    logic exp_pwm, exp_tick, exp_act;
    int ph;
    start_run(10, 3);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 12) begin
        ph       = (k - 3) % 10;
        exp_act  = (k >= 3);
        exp_pwm  = (k >= 3) && (ph < 3);
        exp_tick = (k >= 3) && (ph == 9);
      end else if (k == 13) begin
        exp_act  = 1'b0;
        exp_pwm  = 1'b0;
        exp_tick = 1'b0;
      end else begin
        ph       = (k - 14) % 10;
        exp_act  = 1'b1;
        exp_pwm  = (ph < 3);
        exp_tick = (ph == 9);
      end
      tests_run++;
      if ({pwm_out, period_tick, active} !== {exp_pwm, exp_tick, exp_act}) begin
        tests_failed++;
        $display("[TB] FAIL graceful_stop edge %0d: got pwm/tick/act %b want %b",
                 k, {pwm_out, period_tick, active}, {exp_pwm, exp_tick, exp_act});
      end
      if (k == 4) stop_in = 32'h1;
      if (k == 8) stop_in = 32'h0;
    end
  endtask

  task automatic test_immediate_stop();
    logic [31:0] codes [2];
    logic exp_pwm, exp_act;
    int ph;
    codes[0] = 32'h2;
    codes[1] = 32'h3;
    for (int i = 0; i < 2; i++) begin
      start_run(10, 6);
      for (int k = 1; k <= 24; k++) begin
        tick();
        ph      = (k - 3) % 10;
        exp_act = (k >= 3) && (k <= 15);
        exp_pwm = exp_act && (ph < 6);
        tests_run++;
        if ({pwm_out, active} !== {exp_pwm, exp_act}) begin
          tests_failed++;
          $display("[TB] FAIL immediate_stop code %0d edge %0d: got pwm/act %b want %b",
                   codes[i], k, {pwm_out, active}, {exp_pwm, exp_act});
        end
        if (k == 13) stop_in = codes[i];
      end
    end
  endtask

  task automatic test_invalid_period();
    logic exp_pwm;
    int ph;
    start_run(1, 3);
    for (int k = 1; k <= 15; k++) begin
      tick();
      tests_run++;
      if ({pwm_out, active} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL invalid_period_idle edge %0d: got pwm/act %b want 00",
                 k, {pwm_out, active});
      end
    end
    start_run(10, 3);
    for (int k = 1; k <= 32; k++) begin
      tick();
      ph      = (k - 3) % 10;
      exp_pwm = (k >= 3) && (ph < 3);
      tests_run++;
      if ({pwm_out, period_tick} !== {exp_pwm, (k >= 3) && (ph == 9)}) begin
        tests_failed++;
        $display("[TB] FAIL invalid_period_run edge %0d: got pwm/tick %b want %b",
                 k, {pwm_out, period_tick}, {exp_pwm, (k >= 3) && (ph == 9)});
      end
      if (k == 6) period_in = 1;
    end
  endtask

`ifdef PWM_RAMP_EN
  task automatic test_ramp();
    int hi_tab [5];
    logic exp_pwm;
    int ph, p;
    hi_tab[0] = 2;
    hi_tab[1] = 4;
    hi_tab[2] = 6;
    hi_tab[3] = 7;
    hi_tab[4] = 7;
    start_run(20, 7);
    for (int k = 1; k <= 102; k++) begin
      tick();
      ph      = (k - 3) % 20;
      p       = (k >= 3) ? (k - 3) / 20 : 0;
      if (p > 4) p = 4;
      exp_pwm = (k >= 3) && (ph < hi_tab[p]);
      tests_run++;
      if (pwm_out !== exp_pwm) begin
        tests_failed++;
        $display("[TB] FAIL ramp edge %0d: got %b want %b", k, pwm_out, exp_pwm);
      end
    end
  endtask
`endif

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset_reset_n = 1'b0;
    period_in     = '0;
    duty_in       = '0;
    stop_in       = '0;
    test_reset();
    test_basic_run();
    test_mid_update();
    test_edge_duties();
    test_graceful_stop();
    test_immediate_stop();
    test_invalid_period();
`ifdef PWM_RAMP_EN
    test_ramp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
